piece_sched: RTL and testbench



---
 rtl/piece_pkg.sv | 35 +++
 rtl/piece_sched_if.sv | 35 +++
 rtl/piece_fifo.sv | 94 +++++++++
 rtl/piece_sched.sv | 161 ++++++++++++++++
 tb/tb_piece_sched.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/piece_pkg.sv
// piece_pkg: shared types and constants for the piece scheduler.
//   piece_t        - tetromino type codes (I=0 .. L=6)
//   sched_state_t  - scheduler FSM states
//   NUM_PIECES     - number of legal piece types
//   INVALID_CODE   - LFSR type code that never maps to a piece
//   ENTRY_W        - width of one queued entry {type, rot}
//   is_legal_type  - helper that screens raw LFSR type bits
package piece_pkg;

    typedef enum logic [2:0] {
        I = 3'd0,
        O = 3'd1,
        T = 3'd2,
        S = 3'd3,
        Z = 3'd4,
        J = 3'd5,
        L = 3'd6
    } piece_t;

    typedef enum logic [1:0] {
        S_WARM = 2'd0,
        S_FILL = 2'd1,
        S_FULL = 2'd2
    } sched_state_t;

    localparam int          NUM_PIECES   = 7;
    localparam logic [2:0]  INVALID_CODE = 3'd7;
    localparam int          ENTRY_W      = 5;

    // A raw type code names a piece unless it is the single unused code.
    function automatic logic is_legal_type(input logic [2:0] code);
        return (code != INVALID_CODE);
    endfunction

endpackage

// File: rtl/piece_sched_if.sv
// piece_sched_if: bundle between the LFSR / game FSM side and the scheduler.
//   rand_type[2:0], rand_rot[1:0] : raw LFSR fields
//   take                          : game FSM consumes the head piece
//   piece_valid/type/rot          : head piece
//   next_valid/next_type          : preview piece
//   count                         : queue occupancy
//   ready                         : warm-up finished
// Modports: master = game/LFSR side, slave = scheduler.
interface piece_sched_if #(
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [2:0]       rand_type;
    logic [1:0]       rand_rot;
    logic             take;
    logic             piece_valid;
    logic [2:0]       piece_type;
    logic [1:0]       piece_rot;
    logic             next_valid;
    logic [2:0]       next_type;
    logic [CNT_W-1:0] count;
    logic             ready;

    modport master (
        output rand_type, rand_rot, take,
        input  piece_valid, piece_type, piece_rot, next_valid, next_type, count, ready
    );

    modport slave (
        input  rand_type, rand_rot, take,
        output piece_valid, piece_type, piece_rot, next_valid, next_type, count, ready
    );

endinterface

// File: rtl/piece_fifo.sv
// piece_fifo: small circular queue of {type, rot} entries with head and
// head+1 read ports, so the consumer sees the current piece and a preview.
//   clk, reset      : clock, synchronous active-high reset
//   push, wdata     : enqueue request and entry
//   pop             : dequeue request (ignored when empty)
//   count           : occupancy (registered)
//   head_valid/data : head entry
//   next_valid/data : entry behind the head
// A push is accepted when a slot is free or a pop happens in the same cycle.
// DEPTH need not be a power of two; pointers wrap by explicit compare.
module piece_fifo
    import piece_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic [ENTRY_W-1:0] wdata,
    input  logic               pop,
    output logic [CNT_W-1:0]   count,
    output logic               head_valid,
    output logic [ENTRY_W-1:0] head_data,
    output logic               next_valid,
    output logic [ENTRY_W-1:0] next_data
);

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [ENTRY_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]   head_r;
    logic [PTR_W-1:0]   tail_r;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   count_next_s;
    logic               head_valid_r;
    logic               next_valid_r;
    logic               do_pop_s;
    logic               do_push_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == LAST_PTR) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1'b1);
        end
    endfunction

    // Qualify push/pop against occupancy and compute the next count.
    always_comb begin
        do_pop_s  = pop && (count_r != {CNT_W{1'b0}});
        do_push_s = push && ((count_r != DEPTH_C) || do_pop_s);
        case ({do_push_s, do_pop_s})
            2'b10:   count_next_s = count_r + CNT_W'(1'b1);
            2'b01:   count_next_s = count_r - CNT_W'(1'b1);
            default: count_next_s = count_r;
        endcase
    end

    // Storage, pointers, occupancy and the registered valid flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {ENTRY_W{1'b0}};
            end
            head_r       <= {PTR_W{1'b0}};
            tail_r       <= {PTR_W{1'b0}};
            count_r      <= {CNT_W{1'b0}};
            head_valid_r <= 1'b0;
            next_valid_r <= 1'b0;
        end else begin
            if (do_pop_s) begin
                head_r <= ptr_inc(head_r);
            end
            if (do_push_s) begin
                mem_r[tail_r] <= wdata;
                tail_r        <= ptr_inc(tail_r);
            end
            count_r      <= count_next_s;
            head_valid_r <= (count_next_s != {CNT_W{1'b0}});
            next_valid_r <= (count_next_s > CNT_W'(1'b1));
        end
    end

    assign count      = count_r;
    assign head_valid = head_valid_r;
    assign next_valid = next_valid_r;
    // Read straight from storage; contents past count are don't-care.
    assign head_data  = mem_r[head_r];
    assign next_data  = mem_r[ptr_inc(head_r)];

endmodule

// File: rtl/piece_sched.sv
// piece_sched: turns free-running LFSR bits into a queue of legal pieces for
// the game FSM, exposing a head piece, a one-piece preview and a take strobe.
//   Clock  : sole clock (posedge)
//   reset  : synchronous, active-high; flushes queue, restarts warm-up
//   bus    : piece_sched_if.slave (rand_type, rand_rot, take in;
//            piece_valid/type/rot, next_valid/type, count, ready out)
// FSM: S_WARM waits WARMUP cycles so the LFSR leaves its all-zero start,
// S_FILL samples each cycle, S_FULL idles until the game takes a piece.
// Optional macro PIECE_NO_REPEAT_EN adds a repeat filter: a type equal to the
// last pushed one is rerolled up to MAX_REROLL times before being let through.
module piece_sched
    import piece_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int WARMUP     = 16,
    parameter int MAX_REROLL = 3
) (
    input logic        Clock,
    input logic        reset,
    piece_sched_if.slave bus
);

    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int WARM_W = $clog2(WARMUP + 1);

    localparam logic [1:0]       ST_WARM   = S_WARM;
    localparam logic [1:0]       ST_FILL   = S_FILL;
    localparam logic [1:0]       ST_FULL   = S_FULL;
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP - 1);

    logic [1:0]         state_r;
    logic [1:0]         state_next_s;
    logic [WARM_W-1:0]  warm_cnt_r;
    logic               ready_r;
    logic [CNT_W-1:0]   fifo_count_s;
    logic               head_valid_s;
    logic               next_valid_s;
    logic [ENTRY_W-1:0] head_data_s;
    logic [ENTRY_W-1:0] next_data_s;
    logic               sample_s;
    logic               pop_s;
    logic               free_s;
    logic               code_ok_s;
    logic               repeat_block_s;
    logic               push_s;

`ifdef PIECE_NO_REPEAT_EN
    localparam int RR_W = (MAX_REROLL > 0) ? $clog2(MAX_REROLL + 1) : 1;
    localparam logic [RR_W-1:0] REROLL_LIMIT = RR_W'(MAX_REROLL);

    logic [RR_W-1:0] reroll_r;
    logic [2:0]      last_type_r;
    logic            have_last_r;
`endif

    // Accept/reject decision for the current LFSR sample.
    always_comb begin
        sample_s  = (state_r == ST_FILL);
        pop_s     = bus.take && head_valid_s;
        // A full queue still has room if the head leaves this same cycle.
        free_s    = (fifo_count_s != DEPTH_C) || pop_s;
        code_ok_s = is_legal_type(bus.rand_type);
`ifdef PIECE_NO_REPEAT_EN
        repeat_block_s = have_last_r && (bus.rand_type == last_type_r) &&
                         (reroll_r != REROLL_LIMIT);
`else
        repeat_block_s = 1'b0;
`endif
        push_s = sample_s && code_ok_s && !repeat_block_s && free_s;
    end

    // Next-state logic for the scheduler FSM.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_WARM: begin
                if (warm_cnt_r == WARM_LAST) begin
                    state_next_s = ST_FILL;
                end else begin
                    state_next_s = ST_WARM;
                end
            end
            ST_FILL: begin
                // Stay sampling while the head is being taken, so a
                // simultaneous pop+push can keep the queue topped up.
                if ((fifo_count_s == DEPTH_C) && !pop_s) begin
                    state_next_s = ST_FULL;
                end else begin
                    state_next_s = ST_FILL;
                end
            end
            ST_FULL: begin
                if (pop_s) begin
                    state_next_s = ST_FILL;
                end else begin
                    state_next_s = ST_FULL;
                end
            end
            default: state_next_s = ST_WARM;
        endcase
    end

    // FSM state, warm-up counter and registered ready flag.
    always_ff @(posedge Clock) begin
        if (reset) begin
            state_r    <= ST_WARM;
            warm_cnt_r <= {WARM_W{1'b0}};
            ready_r    <= 1'b0;
        end else begin
            state_r <= state_next_s;
            ready_r <= (state_next_s != ST_WARM);
            if ((state_r == ST_WARM) && (warm_cnt_r != WARM_LAST)) begin
                warm_cnt_r <= warm_cnt_r + WARM_W'(1'b1);
            end else begin
                warm_cnt_r <= {WARM_W{1'b0}};
            end
        end
    end

`ifdef PIECE_NO_REPEAT_EN
    // Repeat filter memory: last pushed type and consecutive reroll count.
    always_ff @(posedge Clock) begin
        if (reset) begin
            reroll_r    <= {RR_W{1'b0}};
            last_type_r <= 3'd0;
            have_last_r <= 1'b0;
        end else if (push_s) begin
            reroll_r    <= {RR_W{1'b0}};
            last_type_r <= bus.rand_type;
            have_last_r <= 1'b1;
        end else if (sample_s && repeat_block_s) begin
            reroll_r <= reroll_r + RR_W'(1'b1);
        end
    end
`endif

    piece_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (Clock),
        .reset      (reset),
        .push       (push_s),
        .wdata      ({bus.rand_type, bus.rand_rot}),
        .pop        (pop_s),
        .count      (fifo_count_s),
        .head_valid (head_valid_s),
        .head_data  (head_data_s),
        .next_valid (next_valid_s),
        .next_data  (next_data_s)
    );

    assign bus.piece_valid = head_valid_s;
    assign bus.piece_type  = head_data_s[4:2];
    assign bus.piece_rot   = head_data_s[1:0];
    assign bus.next_valid  = next_valid_s;
    assign bus.next_type   = next_data_s[4:2];
    assign bus.count       = fifo_count_s;
    assign bus.ready       = ready_r;

endmodule

// File: tb/tb_piece_sched.sv
// tb_piece_sched: directed sequences, a vector table and a randomized run
// against a queue-based reference model of the piece scheduler.
module tb_piece_sched;
    import piece_pkg::*;

    localparam int DEPTH      = 4;
    localparam int WARMUP     = 16;
    localparam int MAX_REROLL = 3;

    logic Clock;
    logic reset;

    piece_sched_if #(.DEPTH(DEPTH)) bus ();

    piece_sched #(
        .DEPTH      (DEPTH),
        .WARMUP     (WARMUP),
        .MAX_REROLL (MAX_REROLL)
    ) dut (
        .Clock (Clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    int checks   = 0;
    int failures = 0;

    // Reference model: a queue of pieces plus the phase of operation.
    int mq_type[$];
    int mq_rot[$];
    int m_mode;        // 0 warming up, 1 sampling, 2 holding full
    int m_wcnt;
    int m_rer;
    int m_last;
    bit m_have_last;

    typedef struct {
        int rt;
        int exp_count;
        bit exp_valid;
        int exp_type;
        bit exp_nv;
        int exp_ntype;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_edge(input bit rs, input int rt, input int rr, input bit tk);
        int sz;
        bit pop;
        bit push;
        bit block;
        if (rs) begin
            mq_type.delete();
            mq_rot.delete();
            m_mode = 0; m_wcnt = 0; m_rer = 0; m_last = 0; m_have_last = 1'b0;
        end else begin
            sz    = mq_type.size();
            pop   = tk && (sz > 0);
            push  = 1'b0;
            block = 1'b0;
            if (m_mode == 1) begin
`ifdef PIECE_NO_REPEAT_EN
                block = m_have_last && (rt == m_last) && (m_rer < MAX_REROLL);
                if (block) m_rer++;
`endif
                push = (rt != 7) && !block && ((sz < DEPTH) || pop);
            end
            if (pop) begin
                void'(mq_type.pop_front());
                void'(mq_rot.pop_front());
            end
            if (push) begin
                mq_type.push_back(rt);
                mq_rot.push_back(rr);
                m_rer = 0; m_last = rt; m_have_last = 1'b1;
            end
            case (m_mode)
                0: begin
                    m_wcnt++;
                    if (m_wcnt == WARMUP) m_mode = 1;
                end
                1: if ((sz == DEPTH) && !pop) m_mode = 2;
                2: if (pop) m_mode = 1;
                default: m_mode = 0;
            endcase
        end
    endtask

    task automatic step(input bit rs, input int rt, input int rr, input bit tk);
        reset         = rs;
        bus.rand_type = 3'(rt);
        bus.rand_rot  = 2'(rr);
        bus.take      = tk;
        @(posedge Clock);
        model_edge(rs, rt, rr, tk);
        @(negedge Clock);
    endtask

    task automatic check_model(input string tag);
        int sz;
        sz = mq_type.size();
        check({tag, " count"},       int'(bus.count),       sz);
        check({tag, " piece_valid"}, int'(bus.piece_valid), int'(sz > 0));
        check({tag, " next_valid"},  int'(bus.next_valid),  int'(sz > 1));
        check({tag, " ready"},       int'(bus.ready),       int'(m_mode != 0));
        if (sz > 0) begin
            check({tag, " piece_type"}, int'(bus.piece_type), mq_type[0]);
            check({tag, " piece_rot"},  int'(bus.piece_rot),  mq_rot[0]);
        end
        if (sz > 1) begin
            check({tag, " next_type"}, int'(bus.next_type), mq_type[1]);
        end
    endtask

    task automatic check_warmup(input string tag);
        for (int i = 1; i < WARMUP; i++) begin
            step(1'b0, 3, 0, 1'b0);
            check({tag, " ready low"}, int'(bus.ready), 0);
            check({tag, " valid low"}, int'(bus.piece_valid), 0);
        end
        step(1'b0, 3, 0, 1'b0);
        check({tag, " ready high"}, int'(bus.ready), 1);
        check({tag, " valid still low"}, int'(bus.piece_valid), 0);
    endtask

    vec_t vecs[5];
    int   exp5[5];

    initial begin
        int k;
        vecs[0] = '{7, 0, 1'b0, 0, 1'b0, 0};
        vecs[1] = '{7, 0, 1'b0, 0, 1'b0, 0};
        vecs[2] = '{2, 1, 1'b1, 2, 1'b0, 0};
        vecs[3] = '{7, 1, 1'b1, 2, 1'b0, 0};
        vecs[4] = '{5, 2, 1'b1, 2, 1'b1, 5};
`ifdef PIECE_NO_REPEAT_EN
        exp5 = '{1, 1, 1, 1, 2};
`else
        exp5 = '{1, 2, 3, 4, 4};
`endif

        // Reset held for two cycles.
        step(1'b1, 3, 0, 1'b0);
        step(1'b1, 3, 0, 1'b0);
        check("rst count",       int'(bus.count),       0);
        check("rst piece_valid", int'(bus.piece_valid), 0);
        check("rst ready",       int'(bus.ready),       0);
        check("rst next_valid",  int'(bus.next_valid),  0);
        check("rst piece_type",  int'(bus.piece_type),  0);
        check("rst piece_rot",   int'(bus.piece_rot),   0);
        check("rst next_type",   int'(bus.next_type),   0);

        check_warmup("warm1");

        // Fill with a constant legal type, rotation varying per cycle.
        k = 0;
        while ((int'(bus.count) != DEPTH) && (k < 40)) begin
            step(1'b0, 3, k % 4, 1'b0);
            check_model("fill");
            k++;
        end
        check("fill reaches full", int'(bus.count), DEPTH);
`ifndef PIECE_NO_REPEAT_EN
        check("fill cycles", k, DEPTH);
        check("fill head type", int'(bus.piece_type), 3);
`endif

        // Full queue: take and a legal sample in the same cycle.
        step(1'b0, 4, 0, 1'b1);
        check("swap count", int'(bus.count), DEPTH);
`ifndef PIECE_NO_REPEAT_EN
        check("swap head rot", int'(bus.piece_rot), 1);
        check("swap head type", int'(bus.piece_type), 3);
`endif
        check_model("swap");
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 7, 0, 1'b1);
            check_model("drain");
        end
        check("tail holds new type", int'(bus.piece_type), 4);
        check("tail count", int'(bus.count), 1);

        // Takes on an empty queue.
        step(1'b0, 7, 0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 7, 0, 1'b1);
            check("empty take count", int'(bus.count), 0);
            check("empty take valid", int'(bus.piece_valid), 0);
            check("empty take no X", int'($isunknown({bus.piece_valid, bus.piece_type,
                  bus.piece_rot, bus.next_valid, bus.next_type, bus.count, bus.ready})), 0);
        end

        // Table: illegal codes interleaved with legal ones.
        for (int i = 0; i < 5; i++) begin
            step(1'b0, vecs[i].rt, i % 4, 1'b0);
            check("vec count", int'(bus.count), vecs[i].exp_count);
            check("vec valid", int'(bus.piece_valid), int'(vecs[i].exp_valid));
            check("vec next_valid", int'(bus.next_valid), int'(vecs[i].exp_nv));
            if (vecs[i].exp_valid) check("vec type", int'(bus.piece_type), vecs[i].exp_type);
            if (vecs[i].exp_nv)    check("vec next_type", int'(bus.next_type), vecs[i].exp_ntype);
            check_model("vec");
        end

        // Constant type from empty: repeat filter behaviour.
        step(1'b0, 7, 0, 1'b1);
        step(1'b0, 7, 0, 1'b1);
        check("pre-repeat empty", int'(bus.count), 0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1, 0, 1'b0);
            check("repeat count", int'(bus.count), exp5[i]);
            check_model("repeat");
        end

        // Reset while holding three pieces in the sampling state.
        k = 0;
        while ((int'(bus.count) != 0) && (k < 10)) begin
            step(1'b0, 7, 0, 1'b1);
            k++;
        end
        check("drain before reset", int'(bus.count), 0);
        step(1'b0, 2, 0, 1'b0);
        step(1'b0, 3, 1, 1'b0);
        step(1'b0, 4, 2, 1'b0);
        check("pre-reset count", int'(bus.count), 3);
        check_model("pre-reset");
        step(1'b1, 3, 0, 1'b0);
        check("mid-rst count", int'(bus.count), 0);
        check("mid-rst valid", int'(bus.piece_valid), 0);
        check("mid-rst ready", int'(bus.ready), 0);
        check("mid-rst next_valid", int'(bus.next_valid), 0);
        check_warmup("warm2");

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(149) == 0), int'($urandom_range(7)),
                 int'($urandom_range(3)), ($urandom_range(2) == 0));
            check_model("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
